// File: rtl/memory_stage.sv
// rtl/memory_stage.sv - pipeline M stage: data-memory req/ack access with timeout and M/W register
// Loads/stores stall upstream while waiting for ack; misalignment or timeout raises a sticky fault.
module memory_stage #(
    parameter int WIDTH    = 32,
    parameter int RA_W     = 3,
    parameter int MAX_WAIT = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             PCSrcM,
    input  logic             RegWriteM,
    input  logic             MemWriteM,
    input  logic             MemtoRegM,
    input  logic [WIDTH-1:0] ALUResultM,
    input  logic [WIDTH-1:0] WriteDataM,
    input  logic [RA_W-1:0]  WA3M,
    output logic             mem_req,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic             mem_ack,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic             StallM,
    output logic             MemErr,
    output logic [WIDTH-1:0] ALUResultMFB,
    output logic             PCSrcW,
    output logic             RegWriteW,
    output logic             MemtoRegW,
    output logic [WIDTH-1:0] ReadDataW,
    output logic [WIDTH-1:0] ALUOutW,
    output logic [RA_W-1:0]  WA3W,
    output logic [WIDTH-1:0] ResultW
);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

    state_t           state_q, state_d;
    logic [7:0]       wcnt_q, wcnt_d;
    logic             mem_err_q, mem_err_d;
    logic             pcsrc_w_q, regwrite_w_q, memtoreg_w_q;
    logic [WIDTH-1:0] read_data_w_q, alu_out_w_q;
    logic [RA_W-1:0]  wa3_w_q;

    logic access, misal, req_c, stall_c, capture_c;

    assign access = MemWriteM | MemtoRegM;
    assign misal  = access & (ALUResultM[1:0] != 2'b00);

    always_comb begin
        req_c     = 1'b0;
        stall_c   = 1'b0;
        capture_c = 1'b0;
        mem_err_d = mem_err_q;
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        case (state_q)
            S_IDLE: begin
                if (!access) begin
                    capture_c = 1'b1;
                end else if (misal) begin
                    mem_err_d = 1'b1;
                end else begin
                    req_c = 1'b1;
                    if (mem_ack) begin
                        capture_c = 1'b1;
                    end else begin
                        stall_c = 1'b1;
                        state_d = S_WAIT;
                        wcnt_d  = 8'd1;
                    end
                end
            end
            default: begin
                if (mem_ack) begin
                    req_c     = 1'b1;
                    capture_c = 1'b1;
                    state_d   = S_IDLE;
                    wcnt_d    = 8'd0;
                end else if (wcnt_q >= MAX_WAIT_C) begin
                    // Timeout: request withdrawn this cycle, pipeline released with a bubble.
                    mem_err_d = 1'b1;
                    state_d   = S_IDLE;
                    wcnt_d    = 8'd0;
                end else begin
                    req_c   = 1'b1;
                    stall_c = 1'b1;
                    wcnt_d  = wcnt_q + 8'd1;
                end
            end
        endcase
        if (reset) begin
            req_c   = 1'b0;
            stall_c = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            wcnt_q        <= 8'd0;
            mem_err_q     <= 1'b0;
            pcsrc_w_q     <= 1'b0;
            regwrite_w_q  <= 1'b0;
            memtoreg_w_q  <= 1'b0;
            read_data_w_q <= '0;
            alu_out_w_q   <= '0;
            wa3_w_q       <= '0;
        end else begin
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            mem_err_q <= mem_err_d;
            // Anything other than a completed capture enters W as a bubble.
            pcsrc_w_q    <= capture_c & PCSrcM;
            regwrite_w_q <= capture_c & RegWriteM;
            memtoreg_w_q <= capture_c & MemtoRegM;
            if (capture_c) begin
                read_data_w_q <= mem_rdata;
                alu_out_w_q   <= ALUResultM;
                wa3_w_q       <= WA3M;
            end
        end
    end

    assign mem_req      = req_c;
    assign mem_we       = MemWriteM;
    assign mem_addr     = ALUResultM;
    assign mem_wdata    = WriteDataM;
    assign StallM       = stall_c;
    assign MemErr       = mem_err_q;
    assign ALUResultMFB = ALUResultM;
    assign PCSrcW       = pcsrc_w_q;
    assign RegWriteW    = regwrite_w_q;
    assign MemtoRegW    = memtoreg_w_q;
    assign ReadDataW    = read_data_w_q;
    assign ALUOutW      = alu_out_w_q;
    assign WA3W         = wa3_w_q;
    assign ResultW      = memtoreg_w_q ? read_data_w_q : alu_out_w_q;

endmodule
